mul_div_unit: RTL and testbench

- Multi-cycle RV32M multiply/divide responder for the EX stage.
- The pipeline issues an operation with START; the unit holds BUSY while it iterates, then returns the result with a one-cycle DONE pulse.
- It replaces single-cycle combinational MUL/DIV/REM paths, so the pipeline stalls on BUSY instead of carrying a 32-bit divider in one cycle.
- Radix-2 iterative, one bit per clock, with RISC-V-mandated special cases resolved in one cycle.

---
 rtl/mul_div_unit_pkg.sv | 25 ++
 rtl/mul_div_unit_div_core.sv | 59 +++++
 rtl/mul_div_unit.sv | 162 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operation codes,
// FSM state encoding and the default datapath width.
package mul_div_unit_pkg;

    localparam int MDU_WIDTH = 32;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_div_core.sv
// Unsigned restoring shift-subtract divider, one quotient bit per enabled
// clock. Remainder (upper half) and quotient (lower half) share one 2*WIDTH
// register. The next-step values are exported so the owner can capture the
// final result on the same edge that completes the last iteration.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_next_o,
    output logic [WIDTH-1:0] rem_next_o
);

    logic [2*WIDTH-1:0] qr_q, qr_d, qr_step;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH:0]     shifted, diff;

    // One restoring step: shift in the next dividend bit, keep the
    // difference only when it did not go negative.
    always_comb begin
        shifted = qr_q[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, divisor_q};
        if (diff[WIDTH]) begin
            qr_step = {shifted[WIDTH-1:0], qr_q[WIDTH-2:0], 1'b0};
        end else begin
            qr_step = {diff[WIDTH-1:0], qr_q[WIDTH-2:0], 1'b1};
        end
        quot_next_o = qr_step[WIDTH-1:0];
        rem_next_o  = qr_step[2*WIDTH-1:WIDTH];
    end

    // Load operands on accept, otherwise advance one step per enable.
    always_comb begin
        qr_d      = qr_q;
        divisor_d = divisor_q;
        if (load_i) begin
            qr_d      = {{WIDTH{1'b0}}, dividend_i};
            divisor_d = divisor_i;
        end else if (en_i) begin
            qr_d = qr_step;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            qr_q      <= '0;
            divisor_q <= '0;
        end else begin
            qr_q      <= qr_d;
            divisor_q <= divisor_d;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M multiply/divide unit. Operands are reduced to magnitudes
// on accept, iterated unsigned one bit per clock, and sign-corrected when the
// final iteration completes. Divide-by-zero and signed overflow finish in
// one cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic             FLUSH,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d, op_in;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
    logic [WIDTH-1:0]   mcand_q, mcand_d, result_q, result_d;
    logic [WIDTH:0]     mul_sum;
    logic               a_neg, b_neg, div_zero, ovf;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               div_load, div_en;
    logic [WIDTH-1:0]   quot_next, rem_next, div_sel;

    // Decode the incoming request: operand signedness, magnitudes, fast cases.
    always_comb begin
        op_in    = mdu_op_e'(OP);
        a_neg    = DATA1[WIDTH-1] && (op_in == MDU_MULH || op_in == MDU_MULHSU ||
                                      op_in == MDU_DIV  || op_in == MDU_REM);
        b_neg    = DATA2[WIDTH-1] && (op_in == MDU_MULH || op_in == MDU_DIV ||
                                      op_in == MDU_REM);
        mag_a    = a_neg ? -DATA1 : DATA1;
        mag_b    = b_neg ? -DATA2 : DATA2;
        div_zero = OP[2] && (DATA2 == '0);
        ovf      = (op_in == MDU_DIV || op_in == MDU_REM) &&
                   (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) && (DATA2 == '1);
    end

    // One shift-add multiply step plus sign fix-up of product and divide result.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        acc_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        prod     = neg_q ? -acc_step : acc_step;
        div_sel  = op_q[1] ? rem_next : quot_next;
        div_sel  = neg_q ? -div_sel : div_sel;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        div_load = 1'b0;
        div_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (START && !FLUSH) begin
                    op_d  = op_in;
                    cnt_d = '0;
                    // Remainder takes the dividend's sign; everything else the XOR.
                    neg_d = (op_in == MDU_REM) ? a_neg : (a_neg ^ b_neg);
                    if (div_zero) begin
                        state_d  = FIN;
                        result_d = OP[1] ? DATA1 : '1;
                    end else if (ovf) begin
                        state_d  = FIN;
                        result_d = OP[1] ? '0 : DATA1;
                    end else begin
                        state_d  = CALC;
                        acc_d    = {{WIDTH{1'b0}}, mag_b};
                        mcand_d  = mag_a;
                        div_load = OP[2];
                    end
                end
            end
            CALC: begin
                if (FLUSH) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[2]) begin
                        div_en = 1'b1;
                    end else begin
                        acc_d = acc_step;
                    end
                    if (cnt_q == LAST) begin
                        state_d = FIN;
                        if (op_q[2]) begin
                            result_d = div_sel;
                        end else if (op_q == MDU_MUL) begin
                            result_d = prod[WIDTH-1:0];
                        end else begin
                            result_d = prod[2*WIDTH-1:WIDTH];
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            op_q     <= MDU_MUL;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
        end
    end

    div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk_i       (CLK),
        .rst_ni      (RESETN),
        .load_i      (div_load),
        .en_i        (div_en),
        .dividend_i  (mag_a),
        .divisor_i   (mag_b),
        .quot_next_o (quot_next),
        .rem_next_o  (rem_next)
    );

    assign BUSY   = (state_q != IDLE);
    assign DONE   = (state_q == FIN);
    assign RESULT = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: results, latency, pulse shape,
// flush, ignored START while busy, and asynchronous reset.
module tb_mul_div_unit;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        START;
    logic [2:0]  OP;
    logic [31:0] DATA1, DATA2;
    logic        FLUSH;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [31:0] last_result;

    mul_div_unit dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .START  (START),
        .OP     (OP),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .FLUSH  (FLUSH),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it to completion. When poke is set, a
    // divide-by-zero request is strobed mid-operation and must be ignored.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input bit poke);
        int lat;
        int busy_n;
        @(negedge CLK);
        OP = op; DATA1 = a; DATA2 = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; OP = 3'b100; DATA1 = $urandom; DATA2 = $urandom;
        lat = 0; busy_n = 0;
        while (!DONE && lat < 100) begin
            if (BUSY) busy_n++;
            if (poke && lat == 5) begin
                START = 1'b1; DATA2 = 32'h0;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
            lat++;
        end
        START = 1'b0;
        if (BUSY) busy_n++;
        $display("op=%0d a=%h b=%h result=%h exp=%h lat=%0d", op, a, b, RESULT, exp, lat);
        chk("latency", lat, exp_lat);
        chk("result", RESULT, exp);
        chk("busy_cycles", busy_n, exp_lat + 1);
        @(posedge CLK); #1;
        chk("done_pulse", {31'b0, DONE}, 32'd0);
        chk("idle_after", {31'b0, BUSY}, 32'd0);
        chk("result_hold", RESULT, exp);
        last_result = exp;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        RESETN = 1'b0; START = 1'b0; FLUSH = 1'b0; OP = 3'b0; DATA1 = '0; DATA2 = '0;
        #1;
        chk("rst_busy", {31'b0, BUSY}, 32'd0);
        chk("rst_done", {31'b0, DONE}, 32'd0);
        chk("rst_result", RESULT, 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK); RESETN = 1'b1;

        // Multiply family
        run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32, 0);
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32, 0);
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 0);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, 0);
        // Divide family
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32, 0);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32, 0);
        run_op(3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32, 0);
        run_op(3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32, 0);
        // Fast paths
        run_op(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 0);
        run_op(3'b111, 32'd5, 32'd0, 32'd5,        0, 0);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 0);

        // Flush mid-divide
        @(negedge CLK);
        OP = 3'b100; DATA1 = 32'd100; DATA2 = 32'd7; START = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (DONE) saw_done = 1'b1;
        end
        chk("flush_busy_before", {31'b0, BUSY}, 32'd1);
        FLUSH = 1'b1;
        @(posedge CLK); #1; FLUSH = 1'b0;
        chk("flush_busy", {31'b0, BUSY}, 32'd0);
        chk("flush_done", {31'b0, DONE | saw_done}, 32'd0);
        chk("flush_result", RESULT, last_result);
        $display("flush: busy=%b done=%b result=%h", BUSY, DONE, RESULT);

        // FLUSH beats START in IDLE
        @(negedge CLK);
        OP = 3'b000; DATA1 = 32'd2; DATA2 = 32'd2; START = 1'b1; FLUSH = 1'b1;
        @(posedge CLK); #1; START = 1'b0; FLUSH = 1'b0;
        chk("flush_start_busy", {31'b0, BUSY}, 32'd0);
        $display("flush+start: busy=%b", BUSY);

        // Immediate multiply with a START strobe while busy
        run_op(3'b000, 32'd3, 32'd4, 32'd12, 32, 1);

        // Asynchronous reset mid-calculation
        @(negedge CLK);
        OP = 3'b100; DATA1 = 32'd100; DATA2 = 32'd7; START = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        repeat (5) @(posedge CLK);
        #3 RESETN = 1'b0;
        #1;
        chk("arst_busy", {31'b0, BUSY}, 32'd0);
        chk("arst_done", {31'b0, DONE}, 32'd0);
        chk("arst_result", RESULT, 32'd0);
        $display("async reset: busy=%b done=%b result=%h", BUSY, DONE, RESULT);
        @(negedge CLK); RESETN = 1'b1;

        run_op(3'b100, 32'd100, 32'd7, 32'd14, 32, 0);
        run_op(3'b110, 32'd100, 32'd7, 32'd2,  32, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
